// File: rtl/slc3_mem_arbiter_if.sv
// Requester-side bus of the SLC-3 memory arbiter: one instance per port.
// The arbiter takes the slave modport, requesters take master.
interface slc3_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/slc3_mem_arbiter.sv
// SLC-3 two-port memory arbiter/sequencer with memory-mapped switches/hex I/O.
// ARB_ROUND_ROBIN_EN selects round-robin contest resolution; default is fixed A priority.
module slc3_mem_arbiter #(
  parameter int              ADDR_W  = 16,
  parameter int              DATA_W  = 16,
  parameter int              RD_LAT  = 2,
  parameter logic [ADDR_W-1:0] IO_ADDR = 16'hFFFF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  slc3_mem_arbiter_if.slave a_if,
  slc3_mem_arbiter_if.slave b_if,
  output logic              o_mem_ce,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic [9:0]        i_sw,
  output logic [15:0]       o_io_reg,
  output logic              o_busy,
  output logic              o_grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t              r_state;
  state_t              w_nxt;
  logic                r_grant;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [2:0]          r_cnt;
  logic [DATA_W-1:0]   r_a_rdata;
  logic [DATA_W-1:0]   r_b_rdata;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [15:0]         r_io_reg;

  logic                w_any;
  logic                w_pick_b;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_io;
  logic                w_lat_hit;

  assign w_any     = a_if.req | b_if.req;
  assign w_io      = (r_addr == IO_ADDR);
  assign w_lat_hit = (r_cnt == LAT);

  always_comb begin
    w_pick_b = r_grant;
    if (a_if.req && b_if.req) begin
`ifdef ARB_ROUND_ROBIN_EN
      w_pick_b = ~r_grant;
`else
      w_pick_b = 1'b0;
`endif
    end else if (a_if.req) begin
      w_pick_b = 1'b0;
    end else if (b_if.req) begin
      w_pick_b = 1'b1;
    end
  end

  always_comb begin
    w_sel_we    = w_pick_b ? b_if.we    : a_if.we;
    w_sel_addr  = w_pick_b ? b_if.addr  : a_if.addr;
    w_sel_wdata = w_pick_b ? b_if.wdata : a_if.wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:  if (w_any) w_nxt = ISSUE;
      ISSUE: w_nxt = (w_io || r_we) ? DONE : WAIT;
      WAIT:  if (w_lat_hit) w_nxt = DONE;
      DONE:  w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (r_state != IDLE);
    o_mem_ce    = (r_state == ISSUE) && !w_io;
    o_mem_we    = o_mem_ce && r_we;
    a_if.ack    = (r_state == DONE) && !r_grant;
    b_if.ack    = (r_state == DONE) && r_grant;
    a_if.rdata  = r_a_rdata;
    b_if.rdata  = r_b_rdata;
    o_mem_addr  = r_mem_addr;
    o_mem_wdata = r_mem_wdata;
    o_io_reg    = r_io_reg;
    o_grant     = r_grant;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_grant     <= 1'b1;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_a_rdata   <= '0;
      r_b_rdata   <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_io_reg    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_pick_b;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            // Memory pins only follow real memory accesses
            if (w_sel_addr != IO_ADDR) begin
              r_mem_addr  <= w_sel_addr;
              r_mem_wdata <= w_sel_wdata;
            end
          end
        end
        ISSUE: begin
          r_cnt <= 3'd1;
          if (w_io && r_we) begin
            r_io_reg <= 16'(r_wdata);
          end else if (w_io) begin
            if (r_grant) r_b_rdata <= DATA_W'(i_sw);
            else         r_a_rdata <= DATA_W'(i_sw);
          end
        end
        WAIT: begin
          if (w_lat_hit) begin
            if (r_grant) r_b_rdata <= i_mem_rdata;
            else         r_a_rdata <= i_mem_rdata;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        DONE: begin
          r_cnt <= '0;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/slc3_mem_arbiter.md
# slc3_mem_arbiter

Two-requester arbiter and sequencer for the SLC-3 single-port on-chip memory. It shares the memory between the CPU datapath (port A) and the program loader/debug port (port B). It decodes the memory-mapped I/O word (switches in, hex-display register out) and sequences each access with a fixed memory read latency. It sits between the CPU memory interface, the loader and the memory/I/O pins in the SLC-3 top level.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- RD_LAT, 2, memory read latency in cycles, from the `mem_ce` cycle to the cycle `mem_rdata` is valid (legal 1..4)
- IO_ADDR, 16'hFFFF, memory-mapped I/O address
- Clk  in  1  system clock; all state changes on the rising edge
- Reset  in  1  asynchronous, active-low reset
- a_req / b_req  in  1  request, held high until the matching ack
- a_we / b_we  in  1  1 = write, 0 = read; stable while req is high
- a_addr / b_addr  in  ADDR_W  access address; stable while req is high
- a_wdata / b_wdata  in  DATA_W  write data; stable while req is high
- a_ack / b_ack  out  1  one-cycle completion pulse
- a_rdata / b_rdata  out  DATA_W  read data; valid in the ack cycle, held until the next ack on that port
- mem_ce  out  1  memory strobe, one cycle per memory access
- mem_we  out  1  memory write enable, qualified by `mem_ce`
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- SW  in  10  board switches
- io_reg  out  16  hex-display register
- busy  out  1  high in every state except IDLE
- grant  out  1  current or last owner: 0 = A, 1 = B

## Operation
- States:
  - IDLE: arbitrate and latch the winner's we, addr and wdata.
  - ISSUE: one cycle; drive the memory strobe.
  - WAIT: count RD_LAT cycles; reads only.
  - DONE: one cycle; pulse the winner's ack.
- Transitions:
  - IDLE -> ISSUE when any req is high.
  - ISSUE -> WAIT for a memory read.
  - ISSUE -> DONE for a memory write or any I/O access.
  - WAIT -> DONE when the counter reaches RD_LAT; `mem_rdata` is captured into the winner's rdata on that edge.
  - DONE -> IDLE.
- Arbitration happens only in IDLE. An in-flight access is never preempted.
- A request arriving while busy waits until the next IDLE.
- Memory access (latched address != IO_ADDR): in ISSUE, `mem_ce` = 1 and `mem_we` = the latched we; `mem_addr` and `mem_wdata` come from the latch.
- I/O access (latched address == IO_ADDR): `mem_ce` stays 0.
  - I/O read returns {6'b0, SW}, sampled in the ISSUE cycle.
  - I/O write loads `io_reg` with the latched wdata on the ISSUE->DONE edge.
- Re-request rule: if req is still high in the cycle after its ack, IDLE treats it as a new transaction. Requesters drop req on the ack cycle.
- `mem_addr` and `mem_wdata` hold their last values outside ISSUE. `mem_we` is 0 outside ISSUE.

## Timing
- Reset values: state IDLE; ack, rdata, `mem_ce`, `mem_we`, `mem_addr`, `mem_wdata`, `io_reg` all 0; `busy` 0; `grant` 1, so the first contested IDLE favours A under round-robin.
- Latency from req sampled high in IDLE to the ack cycle:
  - memory write: 2 cycles
  - I/O read or write: 2 cycles
  - memory read: RD_LAT+2 cycles
- After an ack, IDLE is reached on the next cycle. Back-to-back throughput is one access per 3 cycles (write/I/O) or RD_LAT+3 cycles (read).
- Simultaneous a_req and b_req in IDLE: resolved per Configuration. The loser's request stays pending and is granted at the next IDLE.
- Reset asserted mid-transfer: immediate return to reset values.
  - Any in-flight read data is discarded and no ack is produced.
  - `io_reg` is cleared.
- The req, addr and wdata of the non-granted port are ignored while busy.

## Configuration
- ARB_ROUND_ROBIN_EN defined: a contested IDLE grants the port not equal to `grant` (alternating). An uncontested request is granted immediately. No port waits more than one foreign transaction.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, A always wins a contest. B can starve while A re-requests continuously.
- `grant` is updated identically in both modes on every IDLE->ISSUE edge.

## Test plan
- Reset release, then a_req write 16'h1234 to 16'h0010 -> `mem_ce`=1, `mem_we`=1, `mem_addr`=16'h0010 for exactly 1 cycle; a_ack 2 cycles after req sampled.
- a_req read 16'h0010 with RD_LAT=2 and memory returning 16'h1234 -> a_ack at cycle 4, a_rdata=16'h1234, `mem_we`=0.
- SW=10'b0000001011, b_req read IO_ADDR -> b_rdata=16'h000B, `mem_ce` never asserted; then b_req write 16'h00FF to IO_ADDR -> `io_reg`=16'h00FF.
- a_req and b_req both held high for 4 transactions:
  - with ARB_ROUND_ROBIN_EN, grant order A,B,A,B;
  - without it, A,A,A,A and b_ack never pulses.
- Reset asserted during WAIT of a read -> a_ack stays 0, `busy`=0, `io_reg`=0 immediately; after release a fresh read completes normally.
